// File: rtl/dds_param_scheduler_if.sv
// Update stream into the DDS parameter scheduler.
// Handshake: a transfer happens on a rising clk edge where s_valid and
// s_ready are both 1. The master holds s_time/s_freq/s_phase/s_sync stable
// while s_valid is 1. s_ready may be 0 at any time. s_ready does not depend
// on s_valid.
//   master : drives s_valid, s_time, s_freq, s_phase, s_sync; reads s_ready
//   slave  : reads the update fields; drives s_ready
interface dds_param_scheduler_if #(
  parameter int TIME_W  = 48,
  parameter int FREQ_W  = 48,
  parameter int PHASE_W = 14
);
  logic               s_valid;
  logic               s_ready;
  logic [TIME_W-1:0]  s_time;
  logic [FREQ_W-1:0]  s_freq;
  logic [PHASE_W-1:0] s_phase;
  logic               s_sync;

  modport master (output s_valid, s_time, s_freq, s_phase, s_sync, input s_ready);
  modport slave  (input  s_valid, s_time, s_freq, s_phase, s_sync, output s_ready);
endinterface

// File: rtl/dds_param_scheduler.sv
// Timed parameter queue in front of the DAC-controller phase MAC.
// Buffers timestamped frequency/phase updates, runs the 48-bit timestamp
// counter, and loads the MAC operands when an update's time comes due.
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   start, stop           run-control pulses (IDLE<->RUN)
//   flush                 empties the update FIFO on the next edge
//   s                     update stream (slave side of the interface)
//   timestamp_out         running counter (MAC A)
//   freq_out, phase_out   active frequency / phase (MAC B / C)
//   offset_out            active time offset (MAC D)
//   apply_pulse           1 on the cycle the operands change
//   late_err, clear_err   sticky late-apply flag and its clear
//   fifo_level            occupied FIFO entries
//   state_dbg             FSM state: 0 = IDLE, 1 = RUN
module dds_param_scheduler #(
  parameter int DEPTH   = 16,
  parameter int TIME_W  = 48,
  parameter int FREQ_W  = 48,
  parameter int PHASE_W = 14
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      flush,
  dds_param_scheduler_if.slave      s,
  output logic [TIME_W-1:0]         timestamp_out,
  output logic [FREQ_W-1:0]         freq_out,
  output logic [PHASE_W-1:0]        phase_out,
  output logic [TIME_W-1:0]         offset_out,
  output logic                      apply_pulse,
  output logic                      late_err,
  input  logic                      clear_err,
  output logic [$clog2(DEPTH):0]    fifo_level,
  output logic                      state_dbg
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  typedef struct packed {
    logic [TIME_W-1:0]  t;
    logic [FREQ_W-1:0]  f;
    logic [PHASE_W-1:0] p;
    logic               sync;
  } entry_t;

  state_t          state, state_next;
  logic            run;
  entry_t          mem [DEPTH];
  entry_t          head;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [LW-1:0]   count;
  logic            full, empty;
  logic            push, apply, late;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // start and stop together leave the state unchanged.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start && !stop) state_next = RUN;
      RUN:     if (stop && !start) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    run       = (state == RUN);
    state_dbg = (state == RUN);
  end

  // ---------------- FIFO control ----------------
  assign full    = (count == LW'(DEPTH));
  assign empty   = (count == '0);
  assign s.s_ready = !reset && !full;
  assign head    = mem[rd_ptr];

  // flush wins over both push and apply for the cycle it is asserted.
  always_comb begin
    push  = s.s_valid && s.s_ready && !flush;
    apply = run && !empty && !flush && (head.t <= timestamp_out);
    late  = apply && (head.t < timestamp_out);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{t: s.s_time, f: s.s_freq, p: s.s_phase, sync: s.s_sync};
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + AW'(1);
      if (apply) rd_ptr <= rd_ptr + AW'(1);
      case ({push, apply})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  assign fifo_level = count;

  // ---------------- counter and operands ----------------
  // The operand load shares the edge where the counter leaves the due time,
  // so the MAC first sees A = T+1 with the new operands.
  always_ff @(posedge clk) begin
    if (reset) begin
      timestamp_out <= '0;
      freq_out      <= '0;
      phase_out     <= '0;
      offset_out    <= '0;
      apply_pulse   <= 1'b0;
      late_err      <= 1'b0;
    end else begin
      if (run) timestamp_out <= timestamp_out + TIME_W'(1);
      apply_pulse <= apply;
      if (apply) begin
        freq_out  <= head.f;
        phase_out <= head.p;
        if (head.sync) offset_out <= head.t;
      end
      if (late)           late_err <= 1'b1;
      else if (clear_err) late_err <= 1'b0;
    end
  end
endmodule

// File: tb/tb_dds_param_scheduler.sv
module tb_dds_param_scheduler;
  localparam int DEPTH   = 16;
  localparam int TIME_W  = 48;
  localparam int FREQ_W  = 48;
  localparam int PHASE_W = 14;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0, stop = 1'b0, flush = 1'b0, clear_err = 1'b0;
  logic [TIME_W-1:0]  timestamp_out, offset_out;
  logic [FREQ_W-1:0]  freq_out;
  logic [PHASE_W-1:0] phase_out;
  logic               apply_pulse, late_err, state_dbg;
  logic [$clog2(DEPTH):0] fifo_level;

  dds_param_scheduler_if #(.TIME_W(TIME_W), .FREQ_W(FREQ_W), .PHASE_W(PHASE_W)) bus ();

  dds_param_scheduler #(.DEPTH(DEPTH), .TIME_W(TIME_W), .FREQ_W(FREQ_W), .PHASE_W(PHASE_W)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .flush(flush),
    .s(bus.slave),
    .timestamp_out(timestamp_out), .freq_out(freq_out), .phase_out(phase_out),
    .offset_out(offset_out), .apply_pulse(apply_pulse), .late_err(late_err),
    .clear_err(clear_err), .fifo_level(fifo_level), .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    logic [TIME_W-1:0]  t;
    logic [FREQ_W-1:0]  f;
    logic [PHASE_W-1:0] p;
    logic               sync;
  } ent_t;

  ent_t               q[$];
  bit                 m_run;
  logic [TIME_W-1:0]  m_ts, m_off;
  logic [FREQ_W-1:0]  m_freq;
  logic [PHASE_W-1:0] m_phase;
  bit                 m_apply, m_late;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: predict from the inputs now on the pins, clock, compare,
  // then drop all one-cycle pulses.
  task automatic tick();
    ent_t h;
    bit   do_apply, do_push, late_set;
    late_set = 0;
    if (reset) begin
      q.delete();
      m_run = 0; m_ts = '0; m_off = '0; m_freq = '0; m_phase = '0;
      m_apply = 0; m_late = 0;
    end else begin
      do_apply = m_run && !flush && q.size() > 0 && q[0].t <= m_ts;
      do_push  = bus.s_valid && q.size() < DEPTH && !flush;
      m_apply  = do_apply;
      if (do_apply) begin
        h = q.pop_front();
        m_freq  = h.f;
        m_phase = h.p;
        if (h.sync) m_off = h.t;
        late_set = (h.t < m_ts);
      end
      if (flush) q.delete();
      if (do_push) q.push_back('{bus.s_time, bus.s_freq, bus.s_phase, bus.s_sync});
      if (late_set) m_late = 1;
      else if (clear_err) m_late = 0;
      if (m_run) m_ts = m_ts + 1'b1;
      if (start && !stop) m_run = 1;
      else if (stop && !start) m_run = 0;
    end
    @(posedge clk);
    #1;
    check("timestamp", 64'(timestamp_out), 64'(m_ts));
    check("freq",      64'(freq_out),      64'(m_freq));
    check("phase",     64'(phase_out),     64'(m_phase));
    check("offset",    64'(offset_out),    64'(m_off));
    check("apply",     64'(apply_pulse),   64'(m_apply));
    check("late",      64'(late_err),      64'(m_late));
    check("level",     64'(fifo_level),    64'(q.size()));
    check("s_ready",   64'(bus.s_ready),   64'(!reset && q.size() < DEPTH));
    check("state",     64'(state_dbg),     64'(m_run));
    start = 0; stop = 0; flush = 0; clear_err = 0;
    bus.s_valid = 0;
  endtask

  task automatic drive_update(input logic [TIME_W-1:0] t, input logic [FREQ_W-1:0] f,
                              input logic [PHASE_W-1:0] p, input logic sync);
    bus.s_valid = 1; bus.s_time = t; bus.s_freq = f; bus.s_phase = p; bus.s_sync = sync;
  endtask

  task automatic do_reset();
    reset = 1; tick(); tick();
    reset = 0; tick();
  endtask

  // Advance until the model counter reaches target; bounded.
  task automatic run_until(input logic [TIME_W-1:0] target, input int budget);
    int n = 0;
    while (m_ts != target && n < budget) begin
      tick();
      n++;
    end
    check("run_until_reached", 64'(m_ts == target), 64'd1);
  endtask

  logic [FREQ_W-1:0] rf;
  logic [TIME_W-1:0] rt;

  initial begin
    bus.s_valid = 0; bus.s_time = '0; bus.s_freq = '0; bus.s_phase = '0; bus.s_sync = 0;

    // 1: reset values, counting after start
    do_reset();
    check("reset_ts", 64'(timestamp_out), 64'd0);
    check("reset_ready", 64'(bus.s_ready), 64'd1);
    start = 1; tick();
    tick(); tick(); tick();
    check("count_3", 64'(timestamp_out), 64'd3);

    // 2: on-time sync apply
    do_reset();
    drive_update(48'd100, 48'h0000_0100_0000, 14'h1234, 1'b1); tick();
    start = 1; tick();
    run_until(48'd101, 200);
    check("t2_apply", 64'(apply_pulse), 64'd1);
    check("t2_freq", 64'(freq_out), 64'h0000_0100_0000);
    check("t2_phase", 64'(phase_out), 64'h1234);
    check("t2_offset", 64'(offset_out), 64'd100);
    check("t2_late", 64'(late_err), 64'd0);

    // 3: fill to DEPTH, extra push refused, drain in order
    for (int i = 0; i < DEPTH; i++) begin
      drive_update(48'd200 + 48'(i), 48'(i + 7), 14'(i * 3), 1'b0);
      tick();
    end
    check("t3_level", 64'(fifo_level), 64'(DEPTH));
    check("t3_ready", 64'(bus.s_ready), 64'd0);
    drive_update(48'd190, 48'hdead, 14'h3ff, 1'b1); tick();
    run_until(48'd217, 200);
    check("t3_drained", 64'(fifo_level), 64'd0);
    check("t3_last_freq", 64'(freq_out), 64'(DEPTH - 1 + 7));

    // 4: late apply and clear_err interplay
    run_until(48'd500, 400);
    drive_update(48'd300, 48'h55, 14'h55, 1'b0); tick();
    tick();
    check("t4_late", 64'(late_err), 64'd1);
    check("t4_offset_held", 64'(offset_out), 64'd100);
    clear_err = 1; tick();
    check("t4_cleared", 64'(late_err), 64'd0);
    drive_update(48'd400, 48'h66, 14'h66, 1'b0); tick();
    clear_err = 1; tick();
    check("t4_set_wins", 64'(late_err), 64'd1);

    // 5: stop holds the counter, restart resumes
    do_reset();
    drive_update(48'd60, 48'h77, 14'h77, 1'b1); tick();
    start = 1; tick();
    run_until(48'd49, 100);
    stop = 1; tick();
    for (int i = 0; i < 5; i++) tick();
    check("t5_held", 64'(timestamp_out), 64'd50);
    start = 1; tick();
    run_until(48'd61, 100);
    check("t5_apply", 64'(apply_pulse), 64'd1);

    // 6: flush beats push and apply; reset mid-run
    do_reset();
    drive_update(48'd0, 48'h11, 14'h11, 1'b1); tick();
    drive_update(48'd0, 48'h22, 14'h22, 1'b1); tick();
    start = 1; tick();
    flush = 1; drive_update(48'd5, 48'h33, 14'h33, 1'b0); tick();
    check("t6_flush_level", 64'(fifo_level), 64'd0);
    check("t6_flush_noapply", 64'(apply_pulse), 64'd0);
    for (int i = 0; i < 5; i++) begin
      drive_update(48'd1000 + 48'(i), 48'(i), 14'(i), 1'b1); tick();
    end
    reset = 1; tick();
    check("t6_reset_level", 64'(fifo_level), 64'd0);
    check("t6_reset_state", 64'(state_dbg), 64'd0);
    reset = 0; tick();

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 299) == 0) reset = 1;
      else begin
        reset = 0;
        start     = ($urandom_range(0, 19) == 0);
        stop      = ($urandom_range(0, 39) == 0);
        flush     = ($urandom_range(0, 79) == 0);
        clear_err = ($urandom_range(0, 9) == 0);
        if ($urandom_range(0, 2) == 0) begin
          rt = m_ts + 48'($urandom_range(0, 30));
          if (m_ts >= 48'd8) rt = rt - 48'd8;
          rf = {16'($urandom), $urandom};
          drive_update(rt, rf, 14'($urandom), 1'($urandom));
        end
      end
      tick();
    end
    reset = 0; tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/dds_param_scheduler.md
Name: dds_param_scheduler

Overview:
Timed parameter queue that sits directly upstream of the DAC-controller phase MAC. It buffers frequency/phase updates tagged with an execution time and runs the free-running 48-bit timestamp counter. At the scheduled time it drives the MAC's timestamp, frequency, phase and time-offset operands. The sync flag on an update re-zeroes phase accumulation by capturing the apply time as the new offset.

Parameters:
DEPTH, 16, FIFO entries; power of 2, >= 2
TIME_W, 48, timestamp/offset width
FREQ_W, 48, frequency word width
PHASE_W, 14, phase word width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  pulse: IDLE->RUN
stop  in  1  pulse: RUN->IDLE
flush  in  1  pulse: empty FIFO
s_valid  in  1  update valid
s_ready  out  1  FIFO can accept
s_time  in  TIME_W  execution timestamp
s_freq  in  FREQ_W  frequency word
s_phase  in  PHASE_W  phase word
s_sync  in  1  1 = load offset_out with s_time when applied
timestamp_out  out  TIME_W  running counter (MAC A)
freq_out  out  FREQ_W  active frequency (MAC B)
phase_out  out  PHASE_W  active phase (MAC C)
offset_out  out  TIME_W  active time offset (MAC D)
apply_pulse  out  1  1-cycle, coincident with operand update
late_err  out  1  sticky: an update applied after its time
clear_err  in  1  clears late_err
fifo_level  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Single clock domain; reset is synchronous and active-high.
- Reset: state IDLE, FIFO empty. timestamp_out, freq_out, phase_out, offset_out, apply_pulse, late_err and fifo_level are all 0. s_ready is 0 while reset is high and 1 on the first cycle after.
- FSM states:
  - IDLE: counter holds, no applies.
  - RUN: counter increments by 1 per cycle, applies enabled.
  - Transitions: IDLE->RUN on start; RUN->IDLE on stop. start and stop together: state unchanged. Counter increments begin on the edge after the transition edge.
  - stop holds timestamp_out at its value. Re-start resumes counting; it does not clear the counter.
- Counter wraps 2^TIME_W-1 -> 0. No wrap-aware compare: the time comparison is plain unsigned.
- FIFO: registered, DEPTH entries of {time, freq, phase, sync}.
  - s_ready = !full.
  - Push when s_valid && s_ready at an edge.
  - An entry pushed at edge E is eligible for apply from the cycle after E.
  - Push and pop in the same cycle are allowed; fifo_level is unchanged.
- Apply condition, evaluated in a cycle: RUN && !empty && head.time <= timestamp_out.
  - Pop the head at the next edge.
  - On that edge: freq_out <= head.freq; phase_out <= head.phase; offset_out <= head.time if head.sync, else hold.
  - apply_pulse = 1 for that one cycle.
  - At most one apply per cycle. Back-to-back due entries apply on consecutive cycles.
- Timing contract: entry with time T applied on time produces new operands on the same edge where timestamp_out goes T -> T+1. The first MAC evaluation therefore sees A = T+1.
- Late: apply with head.time < timestamp_out sets late_err on the same edge.
  - A late entry is still applied, never dropped.
  - clear_err clears late_err. Simultaneous set and clear: set wins.
- flush clears the FIFO on the next edge.
  - flush has priority over push and apply: no push, no apply that cycle.
  - Operands hold.
- Entries stay queued while IDLE.
- Operands change only via apply or reset.

Test Plan:
1. Reset -> all outputs 0, s_ready=1 the cycle after reset drops; start -> timestamp_out 0,1,2,... on successive edges.
2. Push {time=100, freq=0x0000_0100_0000, phase=0x1234, sync=1} then start -> apply_pulse when timestamp_out becomes 101; freq_out=0x0000_0100_0000, phase_out=0x1234, offset_out=100, late_err=0.
3. Push DEPTH entries with times 200..215 without popping -> s_ready=0 and fifo_level=DEPTH; extra s_valid is ignored. Entries apply on counts 201..216, one per cycle, in order.
4. Counter at 500, push time=300, sync=0 -> applied on the second edge after the push, late_err=1, offset_out unchanged. clear_err -> 0; clear_err asserted during a late apply -> late_err stays 1.
5. stop at count 50 with an entry time=60 queued -> counter holds 50, no apply. Start -> resumes 51..; apply when the counter becomes 61.
6. flush asserted with s_valid and a due head -> fifo_level=0, no apply_pulse, operands held. Reset mid-RUN with 5 entries queued -> all outputs 0, FIFO empty, IDLE.
